// File: rtl/pn_cag_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pn_cag_ctrl
// Brief   : Gain-loop controller. Measures windowed mean magnitude and steps
//           the gain word toward a target band (ACQ/TRACK/HOLD phases).
// Rev     : 1.0  initial release
// ============================================================================
module pn_cag_ctrl #(
    parameter int            DW        = 24,
    parameter int            GW        = 16,
    parameter int            WIN_LOG2  = 8,
    parameter logic [DW-1:0] TARGET    = DW'(24'h200000),
    parameter logic [DW-1:0] HYST      = DW'(24'h010000),
    parameter int            STEP_FAST = 256,
    parameter int            STEP_SLOW = 16,
    parameter int            LOCK_CNT  = 4,
    parameter int            LOSS_CNT  = 2,
    parameter logic [GW-1:0] GAIN_INIT = GW'(16'h4000)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          En,
    input  logic          Freeze,
    input  logic [DW-1:0] Din,
    input  logic          DinValid,
    output logic [GW-1:0] Gain,
    output logic          Locked,
    output logic [DW-1:0] Level,
    output logic          LevelValid,
    output logic [1:0]    State
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_TRACK = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam int            c_aw       = DW + WIN_LOG2;
    localparam int            c_cw       = $clog2(((LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT) + 1);
    localparam logic [DW-1:0] c_most_neg = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] c_max_pos  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW:0]   c_hi       = {1'b0, TARGET} + {1'b0, HYST};
    localparam logic [GW:0]   c_step_f   = (GW+1)'(STEP_FAST);
    localparam logic [GW:0]   c_step_s   = (GW+1)'(STEP_SLOW);
    localparam logic [c_cw-1:0] c_lock   = c_cw'(LOCK_CNT);
    localparam logic [c_cw-1:0] c_loss   = c_cw'(LOSS_CNT);

    state_t              r_state, w_state_nxt;
    logic [GW-1:0]       r_gain, w_gain_nxt;
    logic                r_locked;
    logic [DW-1:0]       r_level, w_level_nxt;
    logic                r_lv, w_lv_nxt;
    logic [c_aw-1:0]     r_acc, w_acc_nxt;
    logic [WIN_LOG2-1:0] r_cnt, w_cnt_nxt;
    logic [c_cw-1:0]     r_in_cnt, w_in_nxt;
    logic [c_cw-1:0]     r_out_cnt, w_out_nxt;
    logic                r_wend, w_wend_nxt;
    logic [DW-1:0]       r_pend, w_pend_nxt;

    logic [DW-1:0]       w_mag;
    logic [c_aw-1:0]     w_sum;
    logic                w_low, w_high;
    logic [GW:0]         w_step, w_gain_up;
    logic [GW-1:0]       w_gain_stepped;
    logic [c_cw-1:0]     w_in_inc, w_out_inc;

    // Most-negative input has no positive twin; clamp it.
    assign w_mag = Din[DW-1] ? ((Din == c_most_neg) ? c_max_pos : -Din) : Din;
    assign w_sum = r_acc + c_aw'(w_mag);

    // Compare with HYST moved to the mean side so TARGET-HYST can never wrap.
    assign w_low  = ({1'b0, r_pend} + {1'b0, HYST}) < {1'b0, TARGET};
    assign w_high = {1'b0, r_pend} > c_hi;

    assign w_step    = (r_state == S_ACQ) ? c_step_f : c_step_s;
    assign w_gain_up = {1'b0, r_gain} + w_step;

    always_comb begin
        w_gain_stepped = r_gain;
        if (w_low) begin
            w_gain_stepped = w_gain_up[GW] ? {GW{1'b1}} : w_gain_up[GW-1:0];
        end else if (w_high) begin
            w_gain_stepped = ({1'b0, r_gain} < w_step) ? '0 : (r_gain - w_step[GW-1:0]);
        end
    end

    assign w_in_inc  = r_in_cnt + c_cw'(1);
    assign w_out_inc = r_out_cnt + c_cw'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_level_nxt = r_level;
        w_lv_nxt    = 1'b0;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_in_nxt    = r_in_cnt;
        w_out_nxt   = r_out_cnt;
        w_wend_nxt  = 1'b0;
        w_pend_nxt  = r_pend;

        if (!En) begin
            w_state_nxt = S_IDLE;
            w_gain_nxt  = GAIN_INIT;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_in_nxt    = '0;
            w_out_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ACQ;
                    w_gain_nxt  = GAIN_INIT;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_in_nxt    = '0;
                    w_out_nxt   = '0;
                end
                S_HOLD: begin
                    w_acc_nxt = '0;
                    w_cnt_nxt = '0;
                    w_in_nxt  = '0;
                    w_out_nxt = '0;
                    if (!Freeze) begin
                        w_state_nxt = S_ACQ;
                    end
                end
                default: begin
                    if (Freeze) begin
                        w_state_nxt = S_HOLD;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_in_nxt    = '0;
                        w_out_nxt   = '0;
                    end else begin
                        if (DinValid) begin
                            if (r_cnt == {WIN_LOG2{1'b1}}) begin
                                w_acc_nxt  = '0;
                                w_cnt_nxt  = '0;
                                w_wend_nxt = 1'b1;
                                w_pend_nxt = w_sum[c_aw-1:WIN_LOG2];
                            end else begin
                                w_acc_nxt = w_sum;
                                w_cnt_nxt = r_cnt + WIN_LOG2'(1);
                            end
                        end
                        // Window mean captured last edge is acted on here.
                        if (r_wend) begin
                            w_level_nxt = r_pend;
                            w_lv_nxt    = 1'b1;
                            w_gain_nxt  = w_gain_stepped;
                            if (r_state == S_ACQ) begin
                                if (!w_low && !w_high) begin
                                    if (w_in_inc == c_lock) begin
                                        w_state_nxt = S_TRACK;
                                        w_in_nxt    = '0;
                                        w_out_nxt   = '0;
                                    end else begin
                                        w_in_nxt = w_in_inc;
                                    end
                                end else begin
                                    w_in_nxt = '0;
                                end
                            end else begin
                                if (w_low || w_high) begin
                                    if (w_out_inc == c_loss) begin
                                        w_state_nxt = S_ACQ;
                                        w_in_nxt    = '0;
                                        w_out_nxt   = '0;
                                    end else begin
                                        w_out_nxt = w_out_inc;
                                    end
                                end else begin
                                    w_out_nxt = '0;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_gain    <= GAIN_INIT;
            r_locked  <= 1'b0;
            r_level   <= '0;
            r_lv      <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_wend    <= 1'b0;
            r_pend    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gain    <= w_gain_nxt;
            r_locked  <= (w_state_nxt == S_TRACK);
            r_level   <= w_level_nxt;
            r_lv      <= w_lv_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_in_cnt  <= w_in_nxt;
            r_out_cnt <= w_out_nxt;
            r_wend    <= w_wend_nxt;
            r_pend    <= w_pend_nxt;
        end
    end

    assign Gain       = r_gain;
    assign Locked     = r_locked;
    assign Level      = r_level;
    assign LevelValid = r_lv;
    assign State      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pn_cag_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pn_cag_ctrl
// Brief   : Directed self-checking bench for pn_cag_ctrl (main + saturation DUT).
// Rev     : 1.0  initial release
// ============================================================================
module tb_pn_cag_ctrl;

    logic        Clk;
    logic        Rst, En, Freeze, DinValid;
    logic [23:0] Din;
    logic [15:0] Gain;
    logic        Locked, LevelValid;
    logic [23:0] Level;
    logic [1:0]  State;

    logic        s_rst, s_en, s_dv;
    logic [23:0] s_din;
    logic [15:0] s_gain;
    logic        s_locked, s_lv;
    logic [23:0] s_level;
    logic [1:0]  s_state;

    int n_chk  = 0;
    int n_pass = 0;

    pn_cag_ctrl #(
        .DW(24), .GW(16), .WIN_LOG2(2), .TARGET(24'd1000), .HYST(24'd50),
        .STEP_FAST(256), .STEP_SLOW(16), .LOCK_CNT(3), .LOSS_CNT(2),
        .GAIN_INIT(16'h4000)
    ) u_dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Freeze(Freeze), .Din(Din),
        .DinValid(DinValid), .Gain(Gain), .Locked(Locked), .Level(Level),
        .LevelValid(LevelValid), .State(State)
    );

    pn_cag_ctrl #(
        .DW(24), .GW(16), .WIN_LOG2(2), .TARGET(24'd100), .HYST(24'd50),
        .STEP_FAST(256), .STEP_SLOW(16), .LOCK_CNT(3), .LOSS_CNT(2),
        .GAIN_INIT(16'h0180)
    ) u_sat (
        .Clk(Clk), .Rst(s_rst), .En(s_en), .Freeze(1'b0), .Din(s_din),
        .DinValid(s_dv), .Gain(s_gain), .Locked(s_locked), .Level(s_level),
        .LevelValid(s_lv), .State(s_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic feed(input logic [23:0] v);
        Din      = v;
        DinValid = 1'b1;
        tick();
        DinValid = 1'b0;
    endtask

    // Four samples, then the edge on which the window result appears.
    task automatic send_win(input logic [23:0] a, input logic [23:0] b,
                            input logic [23:0] c, input logic [23:0] d);
        feed(a); feed(b); feed(c); feed(d);
        tick();
    endtask

    task automatic chk_win(input string tag, input logic [23:0] lvl, input logic [15:0] g,
                           input logic [1:0] st, input logic lk);
        chk({tag, "_lv"},     32'(LevelValid), 32'd1);
        chk({tag, "_level"},  32'(Level),      32'(lvl));
        chk({tag, "_gain"},   32'(Gain),       32'(g));
        chk({tag, "_state"},  32'(State),      32'(st));
        chk({tag, "_locked"}, 32'(Locked),     32'(lk));
    endtask

    initial begin
        logic [31:0] g;
        Rst = 1'b1; En = 1'b0; Freeze = 1'b0; Din = '0; DinValid = 1'b0;
        s_rst = 1'b1; s_en = 1'b0; s_din = '0; s_dv = 1'b0;
        tick(); tick();
        Rst = 1'b0; s_rst = 1'b0;
        chk("rst_gain",   32'(Gain),       32'h4000);
        chk("rst_locked", 32'(Locked),     32'd0);
        chk("rst_level",  32'(Level),      32'd0);
        chk("rst_lv",     32'(LevelValid), 32'd0);
        chk("rst_state",  32'(State),      32'd0);

        // Continuous 500s: window results on edges 5, 9, 13 after ACQ entry.
        En = 1'b1; Din = 24'd500; DinValid = 1'b1;
        tick();
        chk("acq_entry", 32'(State), 32'd1);
        g = 32'h4000;
        for (int i = 1; i <= 13; i++) begin
            if (i == 13) DinValid = 1'b0;
            tick();
            if (i > 1 && i % 4 == 1) begin
                g = g + 32'h100;
                chk("ramp_level", 32'(Level), 32'd500);
            end
            chk("ramp_lv",    32'(LevelValid), 32'(i > 1 && i % 4 == 1));
            chk("ramp_gain",  32'(Gain),       g);
            chk("ramp_state", 32'(State),      32'd1);
        end
        tick();
        chk("lv_one_cycle", 32'(LevelValid), 32'd0);

        // Three in-band windows lock the loop.
        send_win(24'd1000, 24'(-1000), 24'd1000, 24'(-1000));
        chk_win("lock1", 24'd1000, 16'h4300, 2'd1, 1'b0);
        send_win(24'd1000, 24'(-1000), 24'd1000, 24'(-1000));
        chk_win("lock2", 24'd1000, 16'h4300, 2'd1, 1'b0);
        send_win(24'd1000, 24'(-1000), 24'd1000, 24'(-1000));
        chk_win("lock3", 24'd1000, 16'h4300, 2'd2, 1'b1);

        // Loss of lock; the 1050 window must clear the out-of-band count.
        send_win(24'(-2000), 24'(-2000), 24'(-2000), 24'(-2000));
        chk_win("loss1", 24'd2000, 16'h42F0, 2'd2, 1'b1);
        send_win(24'd1050, 24'd1050, 24'd1050, 24'd1050);
        chk_win("hi_edge_in", 24'd1050, 16'h42F0, 2'd2, 1'b1);
        send_win(24'd1051, 24'd1051, 24'd1051, 24'd1051);
        chk_win("hi_edge_out", 24'd1051, 16'h42E0, 2'd2, 1'b1);
        send_win(24'(-2000), 24'(-2000), 24'(-2000), 24'(-2000));
        chk_win("loss2", 24'd2000, 16'h42D0, 2'd1, 1'b0);

        // Lower band edge in ACQ.
        send_win(24'd950, 24'd950, 24'd950, 24'd950);
        chk_win("lo_edge_in", 24'd950, 16'h42D0, 2'd1, 1'b0);
        send_win(24'd949, 24'd949, 24'd949, 24'd949);
        chk_win("lo_edge_out", 24'd949, 16'h43D0, 2'd1, 1'b0);

        // Freeze after half a window; partial window must be dropped.
        feed(24'd500); feed(24'd500);
        Freeze = 1'b1; Din = 24'd500; DinValid = 1'b1;
        tick();
        chk("frz_state", 32'(State),      32'd3);
        chk("frz_lv",    32'(LevelValid), 32'd0);
        chk("frz_gain",  32'(Gain),       32'h43D0);
        tick(); tick();
        chk("frz_hold_lv",    32'(LevelValid), 32'd0);
        chk("frz_hold_state", 32'(State),      32'd3);
        Freeze = 1'b0; DinValid = 1'b0;
        tick();
        chk("unfrz_state", 32'(State), 32'd1);
        for (int i = 0; i < 4; i++) begin
            feed(24'd500);
            chk("unfrz_early_lv", 32'(LevelValid), 32'd0);
        end
        tick();
        chk_win("unfrz", 24'd500, 16'h44D0, 2'd1, 1'b0);

        // Reset mid-window.
        feed(24'd2000); feed(24'd2000);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("mrst_gain",   32'(Gain),       32'h4000);
        chk("mrst_level",  32'(Level),      32'd0);
        chk("mrst_lv",     32'(LevelValid), 32'd0);
        chk("mrst_state",  32'(State),      32'd0);
        chk("mrst_locked", 32'(Locked),     32'd0);
        tick();
        chk("mrst_acq", 32'(State), 32'd1);
        send_win(24'd500, 24'd500, 24'd500, 24'd500);
        chk_win("mrst_win", 24'd500, 16'h4100, 2'd1, 1'b0);

        // En=0 coinciding with a pending window end discards it.
        feed(24'd500); feed(24'd500); feed(24'd500); feed(24'd500);
        En = 1'b0;
        tick();
        chk("dis_lv",    32'(LevelValid), 32'd0);
        chk("dis_state", 32'(State),      32'd0);
        chk("dis_gain",  32'(Gain),       32'h4000);

        // En=0 mid-window, then a clean window of exactly 4 samples.
        En = 1'b1;
        tick();
        feed(24'd500); feed(24'd500);
        En = 1'b0;
        tick();
        chk("men_state",  32'(State),  32'd0);
        chk("men_gain",   32'(Gain),   32'h4000);
        chk("men_locked", 32'(Locked), 32'd0);
        En = 1'b1;
        tick();
        send_win(24'd500, 24'd500, 24'd500, 24'd500);
        chk_win("men_win", 24'd500, 16'h4100, 2'd1, 1'b0);

        // Saturation instance: most-negative input, gain floors at zero.
        s_en = 1'b1;
        tick();
        for (int w = 0; w < 3; w++) begin
            s_din = 24'h800000;
            s_dv  = 1'b1;
            repeat (4) tick();
            s_dv = 1'b0;
            tick();
            chk("sat_lv",    32'(s_lv),    32'd1);
            chk("sat_level", 32'(s_level), 32'h7FFFFF);
            chk("sat_gain",  32'(s_gain),  (w == 0) ? 32'h0080 : 32'h0000);
            chk("sat_state", 32'(s_state), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
